// File: rtl/noise_filter.sv
// noise_filter: N-sample moving-average low-pass filter for one channel of signed audio.
// A running sum over a circular window costs one add and one subtract per accepted sample.
module noise_filter #(
    parameter int WIDTH  = 24,
    parameter int LOG2_N = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             primed
);
    localparam int N  = 2 ** LOG2_N;
    localparam int AW = WIDTH + LOG2_N;
    localparam logic [LOG2_N:0] CNT_FULL = (LOG2_N + 1)'(N);

    logic [WIDTH-1:0]     window_r [N];
    logic [LOG2_N-1:0]    wp_r;
    logic signed [AW-1:0] acc_r;
    logic [LOG2_N:0]      cnt_r;
    logic [WIDTH-1:0]     data_out_r;
    logic                 valid_r;
    logic                 primed_r;

    logic signed [AW-1:0] in_ext_s;
    logic signed [AW-1:0] old_ext_s;
    logic signed [AW-1:0] acc_next_s;
    logic [LOG2_N:0]      cnt_next_s;
    logic                 accept_s;

    // Next running sum (new sample in, oldest out) and saturating fill count
    always_comb begin
        accept_s   = enable & ~clear;
        in_ext_s   = {{LOG2_N{data_in[WIDTH-1]}}, data_in};
        old_ext_s  = {{LOG2_N{window_r[wp_r][WIDTH-1]}}, window_r[wp_r]};
        acc_next_s = acc_r + in_ext_s - old_ext_s;
        if (cnt_r == CNT_FULL) begin
            cnt_next_s = CNT_FULL;
        end else begin
            cnt_next_s = cnt_r + 1'b1;
        end
    end

    // Window, running sum and registered outputs; clear flushes and beats a same-cycle sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                window_r[i] <= '0;
            end
            wp_r       <= '0;
            acc_r      <= '0;
            cnt_r      <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            primed_r   <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                window_r[i] <= '0;
            end
            wp_r       <= '0;
            acc_r      <= '0;
            cnt_r      <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            primed_r   <= 1'b0;
        end else if (accept_s) begin
            window_r[wp_r] <= data_in;
            wp_r           <= wp_r + 1'b1;
            acc_r          <= acc_next_s;
            cnt_r          <= cnt_next_s;
            // Dropping the low LOG2_N bits is an arithmetic shift: floor toward -infinity
            data_out_r     <= acc_next_s[AW-1:LOG2_N];
            valid_r        <= 1'b1;
            primed_r       <= (cnt_next_s == CNT_FULL);
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign primed    = primed_r;

endmodule

// File: tb/tb_noise_filter.sv
// Self-checking bench for noise_filter: constant vector table, hand corner cases,
// and randomized stimulus against a queue-based moving-average model.
module tb_noise_filter;
    localparam int WIDTH = 24;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             primed;

    int checks = 0;
    int errors = 0;

    longint           hist[$];
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic             m_primed;

    typedef struct {
        logic             en;
        logic             clr;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_out;
        logic             exp_valid;
        logic             exp_primed;
    } vec_t;

    vec_t vecs[$];

    noise_filter #(.WIDTH(WIDTH), .LOG2_N(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .clear    (clear),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .primed   (primed)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic clr, input logic [WIDTH-1:0] din,
                                input logic [WIDTH-1:0] eo, input logic ev, input logic ep);
        vec_t v;
        v.en = en; v.clr = clr; v.din = din;
        v.exp_out = eo; v.exp_valid = ev; v.exp_primed = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint floor_div8(input longint s);
        longint q;
        q = s / 8;
        if (s < 0 && q * 8 != s) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_out    = '0;
        m_valid  = 1'b0;
        m_primed = 1'b0;
    endtask

    // Average of the last 8 accepted samples, zero-padded during warm-up
    task automatic model_step(input logic en, input logic clr, input logic [WIDTH-1:0] din);
        longint s;
        longint q;
        if (clr) begin
            model_reset();
        end else if (en) begin
            hist.push_back(longint'($signed(din)));
            if (hist.size() > 8) void'(hist.pop_front());
            s = 0;
            foreach (hist[i]) s += hist[i];
            q = floor_div8(s);
            m_out   = q[WIDTH-1:0];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        m_primed = (hist.size() == 8);
    endtask

    task automatic drive(input logic en, input logic clr, input logic [WIDTH-1:0] din);
        enable  = en;
        clear   = clr;
        data_in = din;
        @(posedge clk);
        #1;
        model_step(en, clr, din);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " data"}, data_out, m_out);
        chk({tag, " valid"}, {23'd0, valid_out}, {23'd0, m_valid});
        chk({tag, " primed"}, {23'd0, primed}, {23'd0, m_primed});
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        clear   = 1'b0;
        reset_n = 1'b0;
        #7;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int c;
        int sv;

        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(1'b1, 1'b0, 24'd800, 24'(100 * k), 1'b1, (k == 8)));
            if (k == 4) vecs.push_back(mk(1'b0, 1'b0, 24'd123, 24'd400, 1'b0, 1'b0));
        end
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(1'b1, 1'b0, 24'd0, 24'(800 - 100 * k), 1'b1, 1'b1));
        end
        vecs.push_back(mk(1'b1, 1'b0, 24'd1600, 24'd200, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 24'd555, 24'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 24'd80, 24'd10, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 24'd0, 24'd10, 1'b0, 1'b0));

        do_reset();
        chk("reset data", data_out, 24'd0);
        chk("reset valid", {23'd0, valid_out}, 24'd0);
        chk("reset primed", {23'd0, primed}, 24'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].din);
            chk($sformatf("vec%0d data", i), data_out, vecs[i].exp_out);
            chk($sformatf("vec%0d valid", i), {23'd0, valid_out}, {23'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d primed", i), {23'd0, primed}, {23'd0, vecs[i].exp_primed});
        end

        do_reset();
        drive(1'b1, 1'b0, 24'd7);
        chk("floor pos7", data_out, 24'd0);
        do_reset();
        drive(1'b1, 1'b0, 24'hFFFFFF);
        chk("floor neg1", data_out, 24'hFFFFFF);
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 24'hFFFFF8);
            chk($sformatf("neg8 step%0d", k), data_out, 24'(-k));
        end

        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 24'h7FFFFF);
            check_model($sformatf("fs_pos%0d", k));
        end
        chk("fs_pos final", data_out, 24'h7FFFFF);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 24'h800000);
            check_model($sformatf("fs_neg%0d", k));
        end
        chk("fs_neg final", data_out, 24'h800000);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            c  = i % 8;
            sv = (c >= 4) ? c - 8 : c;
            d  = 24'(sv * 2048);
            drive(1'b1, 1'b0, d);
            if (i >= 7) begin
                chk($sformatf("noise%0d data", i), data_out, 24'hFFFC00);
                chk($sformatf("noise%0d valid", i), {23'd0, valid_out}, 24'd1);
            end
        end

        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 24'd1000);
        chk("pre_async data", data_out, 24'd500);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async data", data_out, 24'd0);
        chk("async valid", {23'd0, valid_out}, 24'd0);
        chk("async primed", {23'd0, primed}, 24'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b0, 24'd80);
        chk("post_async data", data_out, 24'd10);
        check_model("post_async");

        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic en;
            logic clr;
            en  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       d = 24'h7FFFFF;
                1:       d = 24'h800000;
                2:       d = 24'($urandom_range(0, 64)) - 24'd32;
                default: d = 24'($urandom);
            endcase
            drive(en, clr, d);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
